// File: rtl/ram_arbiter_if.sv
`timescale 1ns/1ps
// Agent-side request/grant/return bundle for ram_arbiter: two agents (A and B),
// each with one request channel and one read-data return channel.
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
);
  logic                  req_a;
  logic                  req_b;
  logic                  we_a;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic                  gnt_a;
  logic                  gnt_b;
  logic                  rvalid_a;
  logic                  rvalid_b;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic [DATA_WIDTH-1:0] rdata_b;

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b
  );

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b
  );
endinterface

// File: rtl/ram_arbiter.sv
`timescale 1ns/1ps
// Two-agent arbiter for a dual-port RAM: independent round-robin write and read
// arbitration, read-after-write stall, and tagged routing of read data back to the issuer.
module ram_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_arbiter_if.slave          bus,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_wr_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_read,
  output logic [ADDR_WIDTH-1:0] ram_rd_address,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  typedef enum logic {AGENT_A = 1'b0, AGENT_B = 1'b1} agent_t;

  agent_t                wptr;
  agent_t                rptr;
  logic                  wcand_a, wcand_b, rcand_a, rcand_b;
  logic                  wgnt_a, wgnt_b, rsel_a, rsel_b, rgnt_a, rgnt_b;
  logic                  wfire, rfire, hazard;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_id;
  logic [RD_LAT:0]       tag_valid;
  logic [RD_LAT:0]       tag_id;
  logic                  ret_valid_a, ret_valid_b;
  logic [DATA_WIDTH-1:0] ret_data_a, ret_data_b;

  always_comb begin
    wcand_a = bus.req_a & bus.we_a;
    wcand_b = bus.req_b & bus.we_b;
    rcand_a = bus.req_a & ~bus.we_a;
    rcand_b = bus.req_b & ~bus.we_b;
    wgnt_a  = wcand_a & (~wcand_b | (wptr == AGENT_A));
    wgnt_b  = wcand_b & (~wcand_a | (wptr == AGENT_B));
    rsel_a  = rcand_a & (~rcand_b | (rptr == AGENT_A));
    rsel_b  = rcand_b & (~rcand_a | (rptr == AGENT_B));
    wfire   = wgnt_a | wgnt_b;
    waddr   = wgnt_b ? bus.addr_b  : bus.addr_a;
    wdata   = wgnt_b ? bus.wdata_b : bus.wdata_a;
    raddr   = rsel_b ? bus.addr_b  : bus.addr_a;
    // A read hitting the word being written this cycle waits one cycle so it sees the new data
    hazard  = wfire & (rsel_a | rsel_b) & (waddr == raddr);
    rgnt_a  = rsel_a & ~hazard;
    rgnt_b  = rsel_b & ~hazard;
    rfire   = rgnt_a | rgnt_b;
  end

  assign bus.gnt_a    = ~rst & (wgnt_a | rgnt_a);
  assign bus.gnt_b    = ~rst & (wgnt_b | rgnt_b);
  assign bus.rvalid_a = ret_valid_a;
  assign bus.rvalid_b = ret_valid_b;
  assign bus.rdata_a  = ret_data_a;
  assign bus.rdata_b  = ret_data_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr           <= AGENT_A;
      rptr           <= AGENT_A;
      ram_write      <= 1'b0;
      ram_wr_address <= '0;
      ram_data_in    <= '0;
      ram_read       <= 1'b0;
      ram_rd_address <= '0;
      rd_id          <= 1'b0;
    end else begin
      ram_write <= wfire;
      ram_read  <= rfire;
      rd_id     <= rgnt_b;
      if (wfire) begin
        wptr           <= wgnt_a ? AGENT_B : AGENT_A;
        ram_wr_address <= waddr;
        ram_data_in    <= wdata;
      end
      if (rfire) begin
        rptr           <= rgnt_a ? AGENT_B : AGENT_A;
        ram_rd_address <= raddr;
      end
    end
  end

  // Tag stage 0 follows the RAM read command; the last stage lines up with valid RAM data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid[0] <= 1'b0;
      tag_id[0]    <= 1'b0;
    end else begin
      tag_valid[0] <= ram_read;
      tag_id[0]    <= rd_id;
    end
  end

  for (genvar gi = 1; gi <= RD_LAT; gi++) begin : g_tag
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tag_valid[gi] <= 1'b0;
        tag_id[gi]    <= 1'b0;
      end else begin
        tag_valid[gi] <= tag_valid[gi-1];
        tag_id[gi]    <= tag_id[gi-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_valid_a <= 1'b0;
      ret_valid_b <= 1'b0;
      ret_data_a  <= '0;
      ret_data_b  <= '0;
    end else begin
      ret_valid_a <= tag_valid[RD_LAT] & ~tag_id[RD_LAT];
      ret_valid_b <= tag_valid[RD_LAT] &  tag_id[RD_LAT];
      if (tag_valid[RD_LAT] & ~tag_id[RD_LAT]) ret_data_a <= ram_data_out;
      if (tag_valid[RD_LAT] &  tag_id[RD_LAT]) ret_data_b <= ram_data_out;
    end
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for the shared dual-port RAM (separate write and read ports, 4096 x 64 by default). It lets two independent agents, A and B, share the RAM. Write traffic and read traffic are arbitrated independently: each has its own round-robin pointer, so one write and one read can issue in the same cycle. Read data is routed back to the agent that issued the read. The block sits between the agent-side request interfaces and the RAM's write/read ports.

## Interface
- DATA_WIDTH, 64, RAM word width
- ADDR_WIDTH, 12, RAM address width
- RD_LAT, 1, RAM read latency: clock edges from the `ram_read` sample edge until `ram_data_out` is valid (1..4)
- clk  in  1  single clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- req_a / req_b  in  1  agent request; must hold `we_x`, `addr_x`, `wdata_x` stable until granted
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  ADDR_WIDTH  request address
- wdata_a / wdata_b  in  DATA_WIDTH  write data
- gnt_a / gnt_b  out  1  combinational grant; transfer occurs at any edge where req_x & gnt_x
- rvalid_a / rvalid_b  out  1  one-cycle read-data strobe
- rdata_a / rdata_b  out  DATA_WIDTH  read data, valid when rvalid_x
- ram_write  out  1  RAM write enable
- ram_wr_address  out  ADDR_WIDTH  RAM write address
- ram_data_in  out  DATA_WIDTH  RAM write data
- ram_read  out  1  RAM read enable
- ram_rd_address  out  ADDR_WIDTH  RAM read address
- ram_data_out  in  DATA_WIDTH  RAM read data

## Operation
- **Write arbiter**
  - Candidates are the agents with `req_x & we_x`.
  - If one candidate: it is granted.
  - If both: the agent indicated by `wptr` is granted.
  - `wptr` updates only on a granted write; it then points at the other agent.
- **Read arbiter**
  - Same scheme over `req_x & !we_x`, using `rptr`.
- **Concurrency**
  - Each agent has one request, so at most one grant per agent per cycle.
  - A write from A and a read from B (or the reverse) are both granted in the same cycle.
- **Read-after-write hazard**
  - Applies when a read would be granted in the same cycle as a write to the same address.
  - The read grant is suppressed for that cycle and `rptr` is unchanged.
  - The read is granted the next cycle unless the same conflict repeats.
  - Result: the read returns the newly written data.
- **RAM command registers**
  - On a write handshake edge: `ram_write` ← 1, `ram_wr_address` ← addr, `ram_data_in` ← wdata.
  - Otherwise `ram_write` ← 0 and the address/data registers hold.
  - Read side is the same, using `ram_read` and `ram_rd_address`.
- **Return path**
  - A tag shift register, RD_LAT+1 deep, carries {valid, id} alongside each issued read.
  - When the tag emerges: `rdata_id` ← `ram_data_out` and `rvalid_id` ← 1 (registered); the other agent's `rvalid` stays 0.
  - The `rdata_x` register holds its value between strobes.
- **Ordering**
  - Reads return in issue order.
  - Back-to-back reads give back-to-back `rvalid` pulses; there is no backpressure on the return path.

## Timing
- **Reset values**
  - `gnt_a` = `gnt_b` = 0 while `rst` is high.
  - `ram_write` = `ram_read` = 0.
  - All address/data outputs = 0.
  - `rvalid_a` = `rvalid_b` = 0; `rdata_a` = `rdata_b` = 0.
  - `wptr` = `rptr` = A.
  - Tag pipeline cleared.
- **Reset asserted mid-read:** in-flight reads are discarded and no `rvalid` follows after reset is released.
- **Write latency:** handshake at edge E0 → `ram_write` high in cycle E0..E1 → RAM writes at E1.
- **Read latency:** handshake at E0 → `ram_read` high after E0 → data valid after E(1+RD_LAT) → `rvalid_x` high for the one cycle after E(2+RD_LAT). With RD_LAT=1, `rvalid` follows the handshake edge by 3 edges.
- **Throughput:** one write and one read per cycle, sustained.
- **Grant/request relationship:** `gnt_x` depends only on the current `req`/`we`/`addr` and the pointers; it never asserts without `req_x`.
- **Address arithmetic:** the hazard compare covers all ADDR_WIDTH bits. Addresses are unsigned and used as-is; there is no wrap logic.

## Test plan
- **Reset:** assert `rst` mid-cycle (async) → all outputs go to 0 immediately. Release it, then A writes 0x0A5 = 0xDEAD_BEEF → `ram_write`=1, `ram_wr_address`=0x0A5, `ram_data_in`=0xDEADBEEF one cycle later.
- **Write contention:** A and B both write continuously for 6 cycles → grants alternate A, B, A, B, A, B (A first after reset).
- **Concurrent write and read:** A writes 0x010 while B reads 0x020 in the same cycle → both granted. `rvalid_b` pulses 3 edges later (RD_LAT=1) with the RAM contents of 0x020; `rvalid_a` stays 0.
- **Hazard:** A writes 0x100 = 0x55 while B reads 0x100 in the same cycle → `gnt_b`=0 that cycle and `gnt_b`=1 the next. `rdata_b` = 0x55.
- **Read stream with RD_LAT=3:** A issues reads of 0x001..0x004 back-to-back → four consecutive `rvalid_a` pulses in address order, the first 5 edges after the first handshake.
- **Reset mid-read:** A issues a read, then `rst` pulses before the data returns → no `rvalid_a` after reset is released; pointers are back to A.
